bool_sweep_eval: RTL and testbench

//  Programmable N_IN-input, N_OUT-output boolean function evaluator with a built-in truth-table sweeper.

---
 rtl/bool_eval_pkg.sv | 27 ++
 rtl/bool_sweep_eval_lut_bank.sv | 45 ++++
 rtl/bool_sweep_eval.sv | 132 +++++++++++++
 tb/tb_bool_sweep_eval.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bool_eval_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bool_eval_pkg
//  Description : Shared types and constants for the boolean sweep evaluator.
//                Holds the sweep FSM state type, default input/output counts
//                and the helper that locates one function's minterm count
//                inside the flattened ones_cnt bus.
//  Revision    : 1.0 - initial release
// ============================================================================
package bool_eval_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int C_DEF_N_IN  = 3;
    localparam int C_DEF_N_OUT = 2;

    // Each count is N_IN+1 bits wide so an all-ones table (2**N_IN) fits.
    function automatic int cnt_lsb(input int j, input int n_in);
        return j * (n_in + 1);
    endfunction

endpackage : bool_eval_pkg
`default_nettype wire

// File: rtl/bool_sweep_eval_lut_bank.sv
`default_nettype none
// ============================================================================
//  Module      : lut_bank
//  Description : N_OUT truth-table registers of 2**N_IN bits each.
//                Write port : we, sel, data (sel >= N_OUT matches no table).
//                Read port  : vec -> f[j] = table_j[vec], combinational.
//                Ports      : clk, rst (async, active-high, clears tables),
//                             we, sel[SELW], data[2**N_IN], vec[N_IN],
//                             f[N_OUT].
//  Revision    : 1.0 - initial release
// ============================================================================
module lut_bank #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2,
    parameter int SELW  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [SELW-1:0]      sel,
    input  logic [2**N_IN-1:0]   data,
    input  logic [N_IN-1:0]      vec,
    output logic [N_OUT-1:0]     f
);

    localparam int c_TBL_W = 2**N_IN;

    logic [c_TBL_W-1:0] r_tab [N_OUT];

    generate
        for (genvar j = 0; j < N_OUT; j++) begin : g_tab
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tab[j] <= '0;
                end else if (we && (sel == SELW'(j))) begin
                    r_tab[j] <= data;
                end
            end

            assign f[j] = r_tab[j][vec];
        end
    endgenerate

endmodule : lut_bank
`default_nettype wire

// File: rtl/bool_sweep_eval.sv
`default_nettype none
// ============================================================================
//  Module      : bool_sweep_eval
//  Description : Programmable N_IN-input / N_OUT-output boolean evaluator with
//                a built-in exhaustive sweeper. On start it streams every
//                input vector in ascending order with its function values
//                over a valid/ready port, counts each function's minterms and
//                pulses done for one cycle.
//                Ports : clk, rst (async, active-high)
//                        cfg_we, cfg_sel, cfg_table  - table load (IDLE only)
//                        start                       - begin sweep (IDLE only)
//                        busy, done                  - status
//                        out_valid, out_ready        - beat handshake
//                        out_vec, out_f              - beat payload
//                        ones_cnt                    - per-function counts
//  Revision    : 1.0 - initial release
// ============================================================================
module bool_sweep_eval
    import bool_eval_pkg::*;
#(
    parameter int N_IN  = C_DEF_N_IN,
    parameter int N_OUT = C_DEF_N_OUT,
    parameter int SELW  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [SELW-1:0]             cfg_sel,
    input  logic [2**N_IN-1:0]          cfg_table,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_IN-1:0]             out_vec,
    output logic [N_OUT-1:0]            out_f,
    output logic [N_OUT*(N_IN+1)-1:0]   ones_cnt
);

    localparam int              c_CW      = N_IN + 1;
    localparam logic [N_IN-1:0] c_VEC_MAX = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_IN-1:0]    r_vec;
    logic [c_CW-1:0]    r_cnt [N_OUT];
    logic               r_busy;
    logic               r_valid;
    logic               r_done;
    logic [N_OUT-1:0]   w_f;
    logic               w_start_ok;
    logic               w_xfer;
    logic               w_last;
    logic               w_cfg_we;

    // Tables may only change while no sweep is in flight.
    assign w_cfg_we   = cfg_we && (r_state == ST_IDLE);
    assign w_start_ok = start  && (r_state == ST_IDLE);
    assign w_xfer     = (r_state == ST_SWEEP) && out_ready;
    assign w_last     = (r_vec == c_VEC_MAX);

    lut_bank #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .SELW  (SELW)
    ) u_lut_bank (
        .clk  (clk),
        .rst  (rst),
        .we   (w_cfg_we),
        .sel  (cfg_sel),
        .data (cfg_table),
        .vec  (r_vec),
        .f    (w_f)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok)        w_state_nxt = ST_SWEEP;
            ST_SWEEP: if (w_xfer && w_last)  w_state_nxt = ST_DONE;
            ST_DONE:                         w_state_nxt = ST_IDLE;
            default:                         w_state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they line up with
    // the registered state in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_SWEEP);
            r_valid <= (w_state_nxt == ST_SWEEP);
            r_done  <= (w_state_nxt == ST_DONE);
            if (w_start_ok) begin
                r_vec <= '0;
            end else if (w_xfer && !w_last) begin
                r_vec <= r_vec + 1'b1;
            end
        end
    end

    generate
        for (genvar j = 0; j < N_OUT; j++) begin : g_cnt
            // Counts persist after done and restart only on an accepted start.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt[j] <= '0;
                end else if (w_start_ok) begin
                    r_cnt[j] <= '0;
                end else if (w_xfer) begin
                    r_cnt[j] <= r_cnt[j] + c_CW'(w_f[j]);
                end
            end

            assign ones_cnt[cnt_lsb(j, N_IN) +: c_CW] = r_cnt[j];
        end
    endgenerate

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_valid;
    assign out_vec   = r_vec;
    assign out_f     = w_f;

endmodule : bool_sweep_eval
`default_nettype wire

// File: tb/tb_bool_sweep_eval.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_bool_sweep_eval
//  Description : Self-checking bench for bool_sweep_eval. A behavioural model
//                of the sweep (truth tables held as plain arrays, counts as
//                integers) is compared against the DUT every cycle, and a set
//                of hand-computed expectations pins the model. A second
//                1-input / 1-output instance covers the smallest geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bool_sweep_eval;

    localparam int N_IN  = 3;
    localparam int N_OUT = 2;
    localparam int TW    = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cfg_we = 1'b0;
    logic [0:0]   cfg_sel = '0;
    logic [TW-1:0] cfg_table = '0;
    logic         start = 1'b0;
    logic         out_ready = 1'b0;
    logic         busy, done, out_valid;
    logic [2:0]   out_vec;
    logic [1:0]   out_f;
    logic [7:0]   ones_cnt;

    // Smallest geometry instance
    logic         b_cfg_we = 1'b0;
    logic [0:0]   b_cfg_sel = '0;
    logic [1:0]   b_cfg_table = '0;
    logic         b_start = 1'b0;
    logic         b_ready = 1'b0;
    logic         b_busy, b_done, b_valid;
    logic [0:0]   b_vec;
    logic [0:0]   b_f;
    logic [1:0]   b_cnt;

    bool_sweep_eval #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_table(cfg_table), .start(start), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
        .out_f(out_f), .ones_cnt(ones_cnt)
    );

    bool_sweep_eval #(.N_IN(1), .N_OUT(1)) dut_small (
        .clk(clk), .rst(rst), .cfg_we(b_cfg_we), .cfg_sel(b_cfg_sel),
        .cfg_table(b_cfg_table), .start(b_start), .busy(b_busy), .done(b_done),
        .out_valid(b_valid), .out_ready(b_ready), .out_vec(b_vec),
        .out_f(b_f), .ones_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: phase 0 idle, 1 sweeping, 2 done.
    // ------------------------------------------------------------------
    int         m_phase = 0;
    int         m_vec   = 0;
    logic [7:0] m_tab [N_OUT];
    int         m_cnt [N_OUT];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_vec   = 0;
            for (int j = 0; j < N_OUT; j++) begin
                m_tab[j] = '0;
                m_cnt[j] = 0;
            end
        end else begin
            case (m_phase)
                0: begin
                    if (cfg_we) m_tab[cfg_sel] = cfg_table;
                    if (start) begin
                        m_phase = 1;
                        m_vec   = 0;
                        for (int j = 0; j < N_OUT; j++) m_cnt[j] = 0;
                    end
                end
                1: begin
                    if (out_ready) begin
                        for (int j = 0; j < N_OUT; j++) m_cnt[j] += int'(m_tab[j][m_vec]);
                        if (m_vec == TW - 1) m_phase = 2;
                        else                 m_vec++;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Compare process plus beat / done bookkeeping.
    // ------------------------------------------------------------------
    int         cyc = 0;
    int         beats = 0;
    int         done_n = 0;
    int         done_cyc [$];
    logic [7:0] cap [N_OUT];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [7:0] exp_cnt;
        logic [1:0] exp_f;
        exp_cnt = {m_cnt[1][3:0], m_cnt[0][3:0]};
        chk("busy",      busy,      m_phase == 1);
        chk("out_valid", out_valid, m_phase == 1);
        chk("done",      done,      m_phase == 2);
        chk("ones_cnt",  ones_cnt,  exp_cnt);
        if (m_phase == 1 || rst) begin
            exp_f = {m_tab[1][m_vec], m_tab[0][m_vec]};
            chk("out_vec", out_vec, m_vec[2:0]);
            chk("out_f",   out_f,   exp_f);
        end
        if (out_valid && out_ready) begin
            cap[0][out_vec] = out_f[0];
            cap[1][out_vec] = out_f[1];
            beats++;
        end
        if (done) begin
            done_n++;
            done_cyc.push_back(cyc);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tab(input int sel, input logic [7:0] t);
        logic [31:0] s;
        s = sel;
        cfg_we = 1'b1; cfg_sel = s[0]; cfg_table = t;
        tick();
        cfg_we = 1'b0;
    endtask

    function automatic logic ready_pat(input int mode, input int n);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (n % 3 == 0);
        return logic'($urandom_range(0, 1));
    endfunction

    // Pulses start, drives out_ready per mode, returns edges seen from the
    // start edge (inclusive) through the edge that raises done.
    task automatic sweep(input int mode, output int n);
        beats = 0;
        cap[0] = '0; cap[1] = '0;
        start = 1'b1;
        out_ready = ready_pat(mode, 0);
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            out_ready = ready_pat(mode, n);
            tick();
            n++;
        end
        if (!done) chk("sweep_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        logic [7:0] ta, tb;

        m_tab[0] = '0; m_tab[1] = '0; m_cnt[0] = 0; m_cnt[1] = 0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy",  busy, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_done",  done, 1'b0);
        chk("rst_vec",   out_vec, 3'd0);
        chk("rst_f",     out_f, 2'd0);
        chk("rst_cnt",   ones_cnt, 8'h00);
        rst = 1'b0;
        tick();

        // 1: ~(x&y) and x&~y, consumer always ready
        write_tab(0, 8'h3F);
        write_tab(1, 8'h30);
        sweep(0, n);
        chk("t1_cnt",   ones_cnt, 8'h26);
        chk("t1_beats", beats, 8);
        chk("t1_cap0",  cap[0], 8'h3F);
        chk("t1_cap1",  cap[1], 8'h30);
        chk("t1_lat",   n, 9);
        tick();

        // 2: ready pattern 1,0,0,...
        sweep(1, n);
        chk("t2_cnt",   ones_cnt, 8'h26);
        chk("t2_beats", beats, 8);
        chk("t2_cap0",  cap[0], 8'h3F);
        tick();

        // 3: start and cfg_we during SWEEP must be ignored
        d0 = done_n;
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; cfg_we = 1'b1; cfg_sel = 1'b0; cfg_table = 8'h00;
        tick();
        start = 1'b0; cfg_we = 1'b0;
        n = 0;
        while (!done && n < 50) begin tick(); n++; end
        tick();
        chk("t3_one_done", done_n - d0, 1);
        sweep(0, n);
        chk("t3_cnt0", ones_cnt[3:0], 4'd6);
        tick();

        // 4: reset at vec 3
        d0 = done_n;
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (out_vec != 3'd3 && n < 20) begin tick(); n++; end
        chk("t4_reach3", out_vec, 3'd3);
        #2 rst = 1'b1;
        #1;
        chk("t4_busy",  busy, 1'b0);
        chk("t4_valid", out_valid, 1'b0);
        chk("t4_vec",   out_vec, 3'd0);
        chk("t4_f",     out_f, 2'd0);
        chk("t4_cnt",   ones_cnt, 8'h00);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("t4_no_done", done_n - d0, 0);
        sweep(0, n);
        chk("t4_cnt_after", ones_cnt, 8'h00);
        chk("t4_cap", {cap[1], cap[0]}, 16'h0000);
        tick();

        // 5: all-ones / all-zeros
        write_tab(0, 8'hFF);
        write_tab(1, 8'h00);
        sweep(0, n);
        chk("t5_cnt", ones_cnt, 8'h08);
        tick();

        // Random tables with random back-pressure
        for (int k = 0; k < 8; k++) begin
            ta = 8'($urandom);
            tb = 8'($urandom);
            write_tab(0, ta);
            write_tab(1, tb);
            sweep(2, n);
            chk("rnd_cnt0", ones_cnt[3:0], 4'($countones(ta)));
            chk("rnd_cnt1", ones_cnt[7:4], 4'($countones(tb)));
            chk("rnd_cap",  {cap[1], cap[0]}, {tb, ta});
            tick();
        end

        // 6: start held high -> back-to-back sweeps
        write_tab(0, 8'h3F);
        write_tab(1, 8'h30);
        done_cyc.delete();
        start = 1'b1; out_ready = 1'b1;
        repeat (25) tick();
        start = 1'b0;
        repeat (12) tick();
        chk("t6_two_dones", done_cyc.size() >= 2, 1'b1);
        if (done_cyc.size() >= 2)
            chk("t6_gap", done_cyc[1] - done_cyc[0], 10);

        // Smallest geometry: N_IN=1, N_OUT=1, table 2'b10
        b_cfg_we = 1'b1; b_cfg_sel = 1'b0; b_cfg_table = 2'b10;
        tick();
        b_cfg_we = 1'b0;
        b_start = 1'b1; b_ready = 1'b1;
        tick();
        b_start = 1'b0;
        chk("s_valid0", b_valid, 1'b1);
        chk("s_busy0",  b_busy, 1'b1);
        chk("s_vec0",   b_vec, 1'b0);
        chk("s_f0",     b_f, 1'b0);
        tick();
        chk("s_vec1",   b_vec, 1'b1);
        chk("s_f1",     b_f, 1'b1);
        chk("s_cnt_mid", b_cnt, 2'd0);
        tick();
        chk("s_done",   b_done, 1'b1);
        chk("s_valid2", b_valid, 1'b0);
        chk("s_cnt",    b_cnt, 2'd1);
        tick();
        chk("s_done_pulse", b_done, 1'b0);
        chk("s_cnt_hold",   b_cnt, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bool_sweep_eval
`default_nettype wire
